// File: rtl/spec_adder_vl.sv
// spec_adder_vl: variable-latency speculative adder.
// Each carry is predicted from a WINDOW-bit slice of lower operand bits; an
// exact detector compares the speculative result against a full adder. In
// exact mode (MODE=0) a misprediction costs one correction cycle; in
// approximate mode (MODE=1) the speculative sum is released with an error tag.
module spec_adder_vl #(
    parameter int WIDTH  = 16,
    parameter int WINDOW = 4,
    parameter int MODE   = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    localparam bit EXACT_MODE = (MODE == 0);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CORR = 1'b1
    } state_t;

    // Group generate over bits lo..hi-1, seeded with c0 at bit lo.
    function automatic logic window_carry(
        input logic [WIDTH-1:0] gg,
        input logic [WIDTH-1:0] pp,
        input logic             c0,
        input int               lo,
        input int               hi
    );
        logic c;
        c = c0;
        for (int j = 0; j < WIDTH; j++) begin
            if (j >= lo && j < hi) begin
                c = gg[j] | (pp[j] & c);
            end
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Speculative datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] p_w;
    logic [WIDTH-1:0] g_w;
    logic [WIDTH:0]   spec_c_w;
    logic [WIDTH:0]   spec_w;
    logic [WIDTH:0]   exact_w;
    logic [WIDTH:0]   corr_w;
    logic             err_w;

    assign p_w         = a ^ b;
    assign g_w         = a & b;
    assign spec_c_w[0] = cin;

    // Carry into bit i only looks back WINDOW bits; cin is used only when the
    // window reaches bit 0, otherwise the window's incoming carry is guessed 0.
    for (genvar i = 1; i <= WIDTH; i++) begin : g_spec_carry
        localparam int LO = (i > WINDOW) ? (i - WINDOW) : 0;
        assign spec_c_w[i] = window_carry(g_w, p_w, (LO == 0) ? cin : 1'b0, LO, i);
    end

    assign spec_w  = {spec_c_w[WIDTH], p_w ^ spec_c_w[WIDTH-1:0]};
    assign exact_w = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

    // Comparing against the exact sum gives no false positives or negatives.
    assign err_w = (spec_w != exact_w);

    // ------------------------------------------------------------------
    // Control and storage
    // ------------------------------------------------------------------
    state_t           state_q,     state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             cout_q,      cout_d;
    logic             out_err_q,   out_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [WIDTH-1:0] op_a_q,      op_a_d;
    logic [WIDTH-1:0] op_b_q,      op_b_d;
    logic             op_cin_q,    op_cin_d;
    logic             accept_w;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept_w = in_valid && in_ready;

    // Full-width carry resolution on the operands captured for correction.
    assign corr_w = {1'b0, op_a_q} + {1'b0, op_b_q} + {{WIDTH{1'b0}}, op_cin_q};

    // Next-state, output-buffer and counter logic.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_cin_d    = op_cin_q;

        // Consumer drains the single-entry buffer; a load below overrides this.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept_w) begin
                    if (!err_w || !EXACT_MODE) begin
                        sum_d       = spec_w[WIDTH-1:0];
                        cout_d      = spec_w[WIDTH];
                        out_err_d   = err_w;
                        out_valid_d = 1'b1;
                    end else begin
                        op_a_d   = a;
                        op_b_d   = b;
                        op_cin_d = cin;
                        state_d  = CORR;
                    end
                end
            end
            CORR: begin
                // Entry required an empty or draining buffer, so it is free now.
                sum_d       = corr_w[WIDTH-1:0];
                cout_d      = corr_w[WIDTH];
                out_err_d   = 1'b1;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept_w && err_w && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
        end
    end

    // Captured operands for the correction cycle.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; these are only read in CORR, which always follows a load.
        op_a_q   <= op_a_d;
        op_b_q   <= op_b_d;
        op_cin_q <= op_cin_d;
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_spec_adder_vl.sv
// Directed bench for spec_adder_vl: three instances cover exact mode,
// approximate mode and a 2-bit saturating error counter.
module tb_spec_adder_vl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // dut0: exact mode
    logic iv0 = 0, ir0, c0 = 0, ordy0 = 1, ov0, co0, oe0;
    logic [15:0] a0 = 0, b0 = 0, s0, ec0;
    // dut1: approximate mode
    logic iv1 = 0, ir1, c1 = 0, ordy1 = 1, ov1, co1, oe1;
    logic [15:0] a1 = 0, b1 = 0, s1, ec1;
    // dut2: exact mode, 2-bit counter
    logic iv2 = 0, ir2, c2 = 0, ordy2 = 1, ov2, co2, oe2;
    logic [15:0] a2 = 0, b2 = 0, s2;
    logic [1:0]  ec2;

    spec_adder_vl #(.WIDTH(16), .WINDOW(4), .MODE(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .cin(c0),
        .out_valid(ov0), .out_ready(ordy0), .sum(s0), .cout(co0), .out_err(oe0), .err_count(ec0));

    spec_adder_vl #(.WIDTH(16), .WINDOW(4), .MODE(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(c1),
        .out_valid(ov1), .out_ready(ordy1), .sum(s1), .cout(co1), .out_err(oe1), .err_count(ec1));

    spec_adder_vl #(.WIDTH(16), .WINDOW(4), .MODE(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .cin(c2),
        .out_valid(ov2), .out_ready(ordy2), .sum(s2), .cout(co2), .out_err(oe2), .err_count(ec2));

    // Windowed model: carry into bit i is the carry-out of the arithmetic sum
    // of the slice [lo, i-1], with cin added only when lo == 0.
    function automatic logic [16:0] spec_model(input logic [15:0] x, input logic [15:0] y,
                                               input logic ci);
        logic [16:0] c;
        logic [15:0] s;
        int lo, va, vb, tot;
        c[0] = ci;
        for (int i = 1; i <= 16; i++) begin
            lo = (i > 4) ? i - 4 : 0;
            va = 0;
            vb = 0;
            for (int j = lo; j < i; j++) begin
                va = va + (int'(x[j]) << (j - lo));
                vb = vb + (int'(y[j]) << (j - lo));
            end
            tot  = va + vb + ((lo == 0) ? int'(ci) : 0);
            c[i] = ((tot >> (i - lo)) & 1) != 0;
        end
        for (int i = 0; i < 16; i++) s[i] = x[i] ^ y[i] ^ c[i];
        return {c[16], s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL reset_ov0: got %b want 0", ov0); end
        total++; if (s0 !== 16'h0) begin bad++; $display("FAIL reset_sum0: got %h want 0000", s0); end
        total++; if (co0 !== 1'b0) begin bad++; $display("FAIL reset_cout0: got %b want 0", co0); end
        total++; if (oe0 !== 1'b0) begin bad++; $display("FAIL reset_err0: got %b want 0", oe0); end
        total++; if (ec0 !== 16'h0) begin bad++; $display("FAIL reset_cnt0: got %0d want 0", ec0); end
        total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL reset_ready0: got %b want 1", ir0); end
        total++; if (ov1 !== 1'b0 || ov2 !== 1'b0) begin bad++; $display("FAIL reset_ov12: got %b%b want 00", ov1, ov2); end
    endtask

    task automatic test_no_err();
        iv0 = 1; a0 = 16'h1234; b0 = 16'h0101; c0 = 0;
        #1;
        total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL noerr_ready: got %b want 1", ir0); end
        tick();
        iv0 = 0;
        total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL noerr_valid: got %b want 1", ov0); end
        total++; if (s0 !== 16'h1335) begin bad++; $display("FAIL noerr_sum: got %h want 1335", s0); end
        total++; if (co0 !== 1'b0 || oe0 !== 1'b0) begin bad++; $display("FAIL noerr_flags: got cout=%b err=%b want 0 0", co0, oe0); end
        total++; if (ec0 !== 16'd0) begin bad++; $display("FAIL noerr_cnt: got %0d want 0", ec0); end
        tick();
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL noerr_drain: got %b want 0", ov0); end
    endtask

    task automatic test_correction();
        logic [15:0] ta [2] = '{16'h00FF, 16'hFFFF};
        logic [15:0] tb [2] = '{16'h0001, 16'h0000};
        logic        tc [2] = '{1'b0, 1'b1};
        logic [15:0] es [2] = '{16'h0100, 16'h0000};
        logic        ecout [2] = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            iv0 = 1; a0 = ta[k]; b0 = tb[k]; c0 = tc[k];
            tick();
            iv0 = 0;
            total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL corr%0d_early: got valid %b want 0", k, ov0); end
            total++; if (ir0 !== 1'b0) begin bad++; $display("FAIL corr%0d_bubble: got ready %b want 0", k, ir0); end
            tick();
            total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL corr%0d_valid: got %b want 1", k, ov0); end
            total++; if (s0 !== es[k] || co0 !== ecout[k]) begin bad++; $display("FAIL corr%0d_sum: got %b_%h want %b_%h", k, co0, s0, ecout[k], es[k]); end
            total++; if (oe0 !== 1'b1) begin bad++; $display("FAIL corr%0d_err: got %b want 1", k, oe0); end
            total++; if (ec0 !== 16'(k + 1)) begin bad++; $display("FAIL corr%0d_cnt: got %0d want %0d", k, ec0, k + 1); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta [4] = '{16'h0001, 16'h1000, 16'h00F0, 16'h8000};
        logic [15:0] tb [4] = '{16'h0002, 16'h0100, 16'h000F, 16'h8000};
        logic        tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] es [4] = '{16'h0003, 16'h1101, 16'h00FF, 16'h0000};
        logic        ecout [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            iv0 = 1; a0 = ta[k]; b0 = tb[k]; c0 = tc[k];
            #1;
            total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL b2b%0d_ready: got %b want 1", k, ir0); end
            tick();
            total++; if (ov0 !== 1'b1 || s0 !== es[k] || co0 !== ecout[k] || oe0 !== 1'b0) begin
                bad++; $display("FAIL b2b%0d_result: got v=%b %b_%h e=%b want v=1 %b_%h e=0", k, ov0, co0, s0, oe0, ecout[k], es[k]);
            end
        end
        iv0 = 0;
        tick();
        total++; if (ec0 !== 16'd2) begin bad++; $display("FAIL b2b_cnt: got %0d want 2", ec0); end
    endtask

    task automatic test_backpressure();
        ordy0 = 0;
        iv0 = 1; a0 = 16'h0011; b0 = 16'h0022; c0 = 0;
        tick();
        a0 = 16'h0100; b0 = 16'h0200;
        for (int k = 0; k < 5; k++) begin
            total++; if (ir0 !== 1'b0) begin bad++; $display("FAIL bp%0d_ready: got %b want 0", k, ir0); end
            tick();
            total++; if (ov0 !== 1'b1 || s0 !== 16'h0033) begin bad++; $display("FAIL bp%0d_hold: got v=%b %h want v=1 0033", k, ov0, s0); end
        end
        ordy0 = 1;
        #1;
        total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", ir0); end
        tick();
        iv0 = 0;
        total++; if (ov0 !== 1'b1 || s0 !== 16'h0300 || oe0 !== 1'b0) begin bad++; $display("FAIL bp_next: got v=%b %h e=%b want v=1 0300 e=0", ov0, s0, oe0); end
        tick();
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", ov0); end
    endtask

    task automatic test_approx();
        logic [16:0] m, ex;
        logic        e;
        int          nerr;
        iv1 = 1; a1 = 16'h00FF; b1 = 16'h0001; c1 = 0;
        tick();
        iv1 = 0;
        total++; if (ov1 !== 1'b1 || oe1 !== 1'b1) begin bad++; $display("FAIL approx_flags: got v=%b e=%b want 1 1", ov1, oe1); end
        total++; if (s1 === 16'h0100) begin bad++; $display("FAIL approx_notexact: got %h want not 0100", s1); end
        total++; if (s1 !== 16'h00E0 || co1 !== 1'b0) begin bad++; $display("FAIL approx_sum: got %b_%h want 0_00e0", co1, s1); end
        total++; if (ec1 !== 16'd1) begin bad++; $display("FAIL approx_cnt: got %0d want 1", ec1); end
        nerr = 1;
        iv1 = 1;
        for (int n = 0; n < 10000; n++) begin
            a1 = 16'($urandom); b1 = 16'($urandom); c1 = 1'($urandom);
            m  = spec_model(a1, b1, c1);
            ex = {1'b0, a1} + {1'b0, b1} + {16'h0, c1};
            e  = (m != ex);
            if (e) nerr++;
            tick();
            total++; if (ov1 !== 1'b1 || {co1, s1} !== m || oe1 !== e) begin
                bad++; $display("FAIL rand%0d: a=%h b=%h c=%b got v=%b %b_%h e=%b want v=1 %b_%h e=%b",
                                n, a1, b1, c1, ov1, co1, s1, oe1, m[16], m[15:0], e);
            end
        end
        iv1 = 0;
        tick();
        total++; if (ec1 !== 16'(nerr)) begin bad++; $display("FAIL rand_cnt: got %0d want %0d", ec1, nerr); end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 5; k++) begin
            iv2 = 1; a2 = 16'h00FF; b2 = 16'h0001; c2 = 0;
            tick();
            iv2 = 0;
            tick();
            total++; if (ov2 !== 1'b1 || oe2 !== 1'b1 || s2 !== 16'h0100) begin bad++; $display("FAIL sat%0d_result: got v=%b e=%b %h want v=1 e=1 0100", k, ov2, oe2, s2); end
            tick();
        end
        total++; if (ec2 !== 2'd3) begin bad++; $display("FAIL sat_cnt: got %0d want 3", ec2); end
    endtask

    task automatic test_reset_mid_corr();
        iv2 = 1; a2 = 16'h00FF; b2 = 16'h0001; c2 = 0;
        tick();
        iv2 = 0;
        total++; if (ir2 !== 1'b0) begin bad++; $display("FAIL midcorr_state: got ready %b want 0", ir2); end
        rst = 1;
        tick();
        rst = 0;
        total++; if (ov2 !== 1'b0 || ec2 !== 2'd0) begin bad++; $display("FAIL midcorr_reset: got v=%b cnt=%0d want 0 0", ov2, ec2); end
        total++; if (ir2 !== 1'b1) begin bad++; $display("FAIL midcorr_idle: got ready %b want 1", ir2); end
        tick();
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL midcorr_late: got v=%b want 0", ov2); end
    endtask

    task automatic test_reset_wins();
        iv0 = 1; a0 = 16'h00FF; b0 = 16'h0001; c0 = 0;
        rst = 1;
        tick();
        rst = 0; iv0 = 0;
        total++; if (ov0 !== 1'b0 || ec0 !== 16'd0) begin bad++; $display("FAIL rstwin_edge: got v=%b cnt=%0d want 0 0", ov0, ec0); end
        total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL rstwin_idle: got ready %b want 1", ir0); end
        tick();
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL rstwin_noout: got v=%b want 0", ov0); end
    endtask

    initial begin
        test_reset();
        test_no_err();
        test_correction();
        test_back_to_back();
        test_backpressure();
        test_approx();
        test_saturate();
        test_reset_wins();
        test_reset_mid_corr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
